// File: rtl/cpu_dcache_pkg.sv
// Shared types and sizing helpers for the direct-mapped write-through data cache.
//   state_e      : controller states (IDLE, RD_REQ, RD_WAIT, WR_REQ)
//   idx_bits()   : number of index bits for a given line count
//   tag_bits()   : number of tag bits left over from the 30-bit word address
package cpu_dcache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } state_e;

  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int lines);
    return 30 - $clog2(lines);
  endfunction

endpackage

// File: rtl/cpu_dcache_array.sv
// Storage for the data cache: one valid bit, one tag and one 32-bit word per line.
// Ports:
//   clk        : clock
//   i_reset_n  : synchronous active-low clear of every valid bit
//   i_idx      : line index used for both the combinational read and the write
//   o_valid    : valid bit of the indexed line
//   o_tag      : tag of the indexed line
//   o_data     : data word of the indexed line
//   i_wr_en    : write the indexed line (tag, valid=1, enabled byte lanes)
//   i_wr_tag   : tag written with the line
//   i_wr_be    : byte-lane enables, lane i covers bits [8i+7:8i]
//   i_wr_data  : data written into the enabled lanes
module cache_array #(
  parameter int LINES = 64,
  parameter int IDX_W = 6,
  parameter int TAG_W = 24
) (
  input  logic             clk,
  input  logic             i_reset_n,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag,
  output logic [31:0]      o_data,
  input  logic             i_wr_en,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [3:0]       i_wr_be,
  input  logic [31:0]      i_wr_data
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  assign o_valid = r_valid[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_idx] <= 1'b1;
    end
  end

  // Tags and data are not reset; an invalid line's contents are never used.
  always_ff @(posedge clk) begin
    if (i_reset_n && i_wr_en) begin
      r_tag[i_idx] <= i_wr_tag;
      for (int i = 0; i < 4; i++) begin
        if (i_wr_be[i]) begin
          r_data[i_idx][8*i +: 8] <= i_wr_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/cpu_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the core's
// data port and a valid/ready backing memory.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   addr, re, we, din     : core request (byte address, read, byte-lane write enables, write data)
//   dout                  : read data, valid the cycle after a hitting request
//   stall                 : core must hold its request while high
//   mem_req_valid/ready   : memory request handshake
//   mem_req_addr/we/data  : word-aligned address, write byte enables (0 = read), write data
//   mem_resp_valid/data   : read response, one pulse per read request
module cpu_dcache
  import cpu_dcache_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic [3:0]  mem_req_we,
  output logic [31:0] mem_req_data,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int IDX_W = idx_bits(LINES);
  localparam int TAG_W = tag_bits(LINES);

  state_e      r_state;
  logic [29:0] r_req_waddr;   // captured word address, addr[31:2]
  logic        r_req_rd;      // captured read (already cleared when a write was present)
  logic [3:0]  r_req_we;
  logic [31:0] r_req_din;
  logic [31:0] r_dout;
  logic        r_mem_valid;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_we;
  logic [31:0] r_mem_data;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_req_tag;
  logic             w_line_valid;
  logic [TAG_W-1:0] w_line_tag;
  logic [31:0]      w_line_data;
  logic             w_hit;
  logic             w_rd_miss;
  logic             w_deliver;
  logic             w_stall;
  logic             w_arr_we;
  logic [3:0]       w_arr_be;
  logic [31:0]      w_arr_data;
  logic [1:0]       w_unused_addr_lsb;

  // Byte offset within the word is not meaningful to a word cache.
  assign w_unused_addr_lsb = addr[1:0];

  assign w_idx     = r_req_waddr[IDX_W-1:0];
  assign w_req_tag = r_req_waddr[29 -: TAG_W];

  cache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk       (clk),
    .i_reset_n (reset),
    .i_idx     (w_idx),
    .o_valid   (w_line_valid),
    .o_tag     (w_line_tag),
    .o_data    (w_line_data),
    .i_wr_en   (w_arr_we),
    .i_wr_tag  (w_req_tag),
    .i_wr_be   (w_arr_be),
    .i_wr_data (w_arr_data)
  );

  assign w_hit     = w_line_valid && (w_line_tag == w_req_tag);
  assign w_deliver = (r_state == IDLE) && r_req_rd && w_hit;
  assign w_rd_miss = (r_state == IDLE) && r_req_rd && !w_hit;
  assign w_stall   = (r_state != IDLE) || w_rd_miss;

  // Refill writes the whole word; a write hit merges only the enabled lanes.
  // A write miss leaves the array untouched (no allocate).
  assign w_arr_we   = ((r_state == RD_WAIT) && mem_resp_valid) ||
                      ((r_state == WR_REQ) && mem_req_ready && w_hit);
  assign w_arr_be   = (r_state == RD_WAIT) ? 4'hF : r_req_we;
  assign w_arr_data = (r_state == RD_WAIT) ? mem_resp_data : r_req_din;

  // Hit data is forwarded straight from the array in the cycle after the
  // request; r_dout keeps the last delivered word for every other cycle.
  assign dout          = w_deliver ? w_line_data : r_dout;
  assign stall         = w_stall;
  assign mem_req_valid = r_mem_valid;
  assign mem_req_addr  = r_mem_addr;
  assign mem_req_we    = r_mem_we;
  assign mem_req_data  = r_mem_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_req_waddr <= '0;
      r_req_rd    <= 1'b0;
      r_req_we    <= 4'h0;
      r_req_din   <= '0;
      r_dout      <= '0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 4'h0;
      r_mem_data  <= '0;
    end else begin
      if (!w_stall) begin
        r_req_waddr <= addr[31:2];
        r_req_rd    <= re && (we == 4'h0);
        r_req_we    <= we;
        r_req_din   <= din;
      end

      if (w_deliver) begin
        r_dout <= w_line_data;
      end

      case (r_state)
        IDLE: begin
          if (w_rd_miss) begin
            r_state     <= RD_REQ;
            r_mem_valid <= 1'b1;
            r_mem_addr  <= {r_req_waddr, 2'b00};
            r_mem_we    <= 4'h0;
          end else if (we != 4'h0) begin
            // Writes go to memory straight from the capture edge.
            r_state     <= WR_REQ;
            r_mem_valid <= 1'b1;
            r_mem_addr  <= {addr[31:2], 2'b00};
            r_mem_we    <= we;
            r_mem_data  <= din;
          end
        end
        RD_REQ: begin
          if (mem_req_ready) begin
            r_state     <= RD_WAIT;
            r_mem_valid <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (mem_resp_valid) begin
            r_state <= IDLE;
          end
        end
        WR_REQ: begin
          if (mem_req_ready) begin
            r_state     <= IDLE;
            r_mem_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu_dcache.md
# cpu_dcache

Direct-mapped, write-through, no-write-allocate data cache that serves the core's data-memory port (`dcache_addr`, `dcache_we`, `dcache_re`, `dcache_din`, `dcache_dout`, `stall`). It sits between the Riscv151 core and the backing memory. Read hits return data one cycle after the request, like a synchronous SRAM. Misses and all writes raise `stall` while the block runs a valid/ready transaction on the memory side.

## Interface
- `LINES`, default 64: number of one-word lines; must be a power of 2 and at least 2.
- `clk` in 1: single clock; everything updates on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `addr` in 32: word byte address from the core; bits [1:0] are ignored.
- `re` in 1: read request.
- `we` in 4: byte-lane write enables; lane i covers bits [8i+7:8i].
- `din` in 32: write data.
- `dout` out 32: read data.
- `stall` out 1: core must hold `addr`/`re`/`we`/`din` and its own pipeline while this is high.
- `mem_req_valid` out 1: memory request valid.
- `mem_req_ready` in 1: memory accepts the request this cycle.
- `mem_req_addr` out 32: word-aligned request address.
- `mem_req_we` out 4: write byte enables; 0 means the request is a read.
- `mem_req_data` out 32: write data.
- `mem_resp_valid` in 1: read data valid; one pulse per read request.
- `mem_resp_data` in 32: read data.

## Operation
- Address split: index = `addr[2 +: log2(LINES)]`; tag = `addr[31 : 2+log2(LINES)]`.
- Request capture: on any edge where `stall`=0, the block registers `addr`, `re`, `we` and `din` into `req_q`.
- Write priority: if `we`≠0, the request is a write and `re` is ignored.
- No request: `re`=0 and `we`=0 captures an idle slot. No action; `dout` holds.
- FSM states:
  - IDLE: serves hits.
    - If `req_q` is a read and the indexed line is valid with a matching tag: `dout` ← line data, `stall`=0.
    - If `req_q` is a read that misses: `stall`=1, go to RD_REQ.
    - A write moves IDLE→WR_REQ at the capture edge.
  - RD_REQ: `mem_req_valid`=1, `mem_req_we`=0, `mem_req_addr`={`req_q` addr[31:2],2'b00}. On `mem_req_ready`, go to RD_WAIT.
  - RD_WAIT: on `mem_resp_valid`, write data, tag and valid=1 into the line, then go to IDLE. The refilled line now hits, so `dout` = `mem_resp_data` in the next cycle.
  - WR_REQ: `mem_req_valid`=1 carrying `req_q` address, `we` and `din`.
    - On `mem_req_ready`: if the line is a tag hit, merge the enabled bytes of `din` into it. A miss does not allocate. Then go to IDLE.
    - No response is expected for writes.
- `stall` = (state≠IDLE) or (state=IDLE and `req_q` is a read miss).
- Memory-side outputs hold stable while `mem_req_valid`=1 and `mem_req_ready`=0.
- `dout` changes only when a hit is delivered; it holds during stalls and writes.
- `mem_resp_valid` outside RD_WAIT is ignored and changes no state.
- Reset (`reset`=0 at an edge) has these effects:
  - All valid bits cleared, state IDLE, `req_q` idle.
  - `dout`=0, `stall`=0, `mem_req_valid`=0, `mem_req_we`=0, `mem_req_addr`=0, `mem_req_data`=0.
  - A miss or write in flight is abandoned, and a late response is ignored.

## Timing
- Read hit: request in cycle N, `dout` valid in N+1 with `stall`=0.
- Read miss, minimum latency:
  - N+1: `stall`=1.
  - N+2: RD_REQ; `ready`=1 this cycle.
  - N+3: RD_WAIT; `resp_valid`=1 this cycle.
  - N+4: IDLE; `dout` valid, `stall`=0.
  - Each cycle of `ready` or `resp` delay adds one cycle.
- Write: request in N; `mem_req_valid`=1 from N+1; `stall` falls the cycle after the accepting edge, so the minimum is 1 stall cycle.
- Back-to-back hits sustain 1 request per cycle.

## Structure
- Package `cpu_dcache_pkg`:
  - state enum {IDLE, RD_REQ, RD_WAIT, WR_REQ}.
  - functions `idx_bits(LINES)` and `tag_bits(LINES)`.
- Sub-module `cache_array`: valid/tag/data flops with combinational read by index, byte-lane write enable and a synchronous clear of all valid bits.

## Test plan
- Reset, then read 0x100 (miss) with an always-ready memory returning 0xDEADBEEF:
  - `stall` high for exactly 3 cycles.
  - `dout`=0xDEADBEEF.
  - Re-reading 0x100 hits in 1 cycle with no memory request.
- Write through and refill:
  - Read miss on 0x200 returns 0x11223344 and fills the line.
  - Write `we`=4'b0010, `din`=0x0000AA00 to 0x200: one memory write (`mem_req_we`=0010).
  - Re-read 0x200 hits with `dout`=0x1122AA44.
- Write miss: write 0x300 with `we`=1111, then read 0x300 → a read miss goes to memory, confirming no allocate.
- Conflict eviction: with `LINES`=64, read 0x0 then 0x100 (same index, different tag) → both miss; re-reading 0x0 misses again.
- Backpressure:
  - Hold `mem_req_ready`=0 for 5 cycles and delay `resp` by 4 → `stall` held throughout.
  - Request fields stay stable while waiting.
  - Stray `mem_resp_valid` while IDLE changes nothing.
- Reset mid-miss:
  - Assert `reset`=0 in RD_WAIT → all outputs take reset values next cycle.
  - A late `resp` is ignored, and a subsequent read of the same address misses.
